prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Byte-stream writer for the instruction memory. The processor core only ever reads instruction memory; this block
//  fills it. It accepts a framed byte stream (sync, 16-bit word count, big-endian words) and issues one 32-bit word
//  write per assembled instruction. It holds the core in reset-hold until the image is fully loaded.
// PARAMETERS
//  BASE_ADDR  32'h0000_0000  byte address of first word written (matches PC reset value)
//  MAX_WORDS  256            instruction memory depth in words; larger counts are rejected
//  SYNC_BYTE  8'hA5          frame start marker
// PORTS
//  CLK         in   1   system clock, all logic on rising edge
//  RST         in   1   synchronous, active-high reset
//  byte_valid  in   1   byte_data is valid this cycle
//  byte_data   in   8   incoming stream byte
//  byte_ready  out  1   loader can accept a byte this cycle
//  mem_we      out  1   instruction memory write strobe, one-cycle pulse per word
//  mem_addr    out  32  byte address of write, word aligned
//  mem_wdata   out  32  instruction word to write
//  cpu_hold    out  1   1 = core held (PC frozen at BASE_ADDR); 0 = core runs
//  done        out  1   image loaded successfully (sticky until RST)
//  error       out  1   frame rejected, count > MAX_WORDS (sticky until RST)
// BEHAVIOUR
//  Reset: state=IDLE. byte_ready=1, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=1, done=0, error=0.
//  Reset at any point, including mid-frame, returns to IDLE. No mem_we is issued after RST. Memory keeps partial contents.
//  Handshake: a byte is consumed on a rising edge with byte_valid && byte_ready. byte_valid may be held high.
//  States:
//   IDLE   ready=1. Consumed byte == SYNC_BYTE -> LEN_HI. Any other byte is discarded and the state stays IDLE.
//   LEN_HI ready=1. Consumed byte -> count[15:8]. Go to LEN_LO.
//   LEN_LO ready=1. Consumed byte -> count[7:0]. Then use the full 16-bit count:
//          count==0 -> DONE; count>MAX_WORDS -> ERR; otherwise -> DATA with byte_idx=0, word_idx=0.
//   DATA   ready=1. Bytes shift in MSB first: wdata = {wdata[23:0], byte}. byte_idx increments and wraps at 3.
//          The 4th consumed byte -> WRITE.
//   WRITE  ready=0 (one bubble per word). mem_we=1 for exactly this cycle.
//          mem_addr = BASE_ADDR + 4*word_idx; mem_wdata = assembled word.
//          Next cycle: word_idx++. If word_idx+1 == count -> DONE, else -> DATA.
//   DONE   ready=0, done=1, cpu_hold=0, mem_we=0. Terminal until RST. Further bytes are not consumed.
//   ERR    ready=0, error=1, cpu_hold=1. Terminal until RST.
//  Latency: 4th byte consumed at edge N -> mem_we high during cycle N+1.
//           After the last word's WRITE cycle, done=1 and cpu_hold=0 from the next cycle.
//  Arithmetic: word_idx is 16 bits. Address = BASE_ADDR + {word_idx,2'b00}, 32-bit, with no wrap inside a legal frame.
//  MAX_WORDS boundary: count==MAX_WORDS is accepted; MAX_WORDS+1 goes to ERR.
//  byte_valid low mid-word: assembly pauses. Partial wdata and byte_idx are held indefinitely (no timeout).
// TESTING
//  1 Stream A5 00 02 20 08 00 05 01 09 50 20 -> we@addr 0x0 data 0x20080005, then we@0x4 data 0x01095020.
//    done=1 and cpu_hold=0 the cycle after the 2nd write.
//  2 Stream 00 FF 13 A5 00 01 AA BB CC DD -> first three bytes ignored; single write 0xAABBCCDD @0x0; done=1.
//  3 Stream A5 00 00 -> no mem_we ever; done=1 the cycle after byte 3; cpu_hold=0.
//  4 Stream A5 01 01 (257 > 256) -> error=1, cpu_hold stays 1, byte_ready=0, no writes.
//    Repeat with A5 01 00 -> accepted.
//  5 byte_valid held high for a 3-word frame -> byte_ready low only in each WRITE cycle.
//    All 12 data bytes land correctly; addresses are 0x0, 0x4, 0x8.
//  6 RST pulsed after the 2nd data byte of word 1 -> no mem_we; outputs at reset values.
//    A fresh frame A5 00 01 11 22 33 44 then writes 0x11223344 @0x0.

Source files
------------

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Fills the instruction memory from a framed byte stream. The core never
// writes this memory itself. It is held in reset-hold until a complete image
// has been written.
//
// Frame layout: SYNC_BYTE, word count (16-bit, big-endian), then the words,
// each sent as four bytes, most significant byte first.
//
// Ports
//   CLK         in   1   system clock; all logic runs on the rising edge
//   RST         in   1   synchronous, active-high reset
//   byte_valid  in   1   byte_data is valid this cycle
//   byte_data   in   8   incoming stream byte
//   byte_ready  out  1   loader can accept a byte this cycle
//   mem_we      out  1   instruction memory write strobe, one cycle per word
//   mem_addr    out  32  word-aligned byte address of the write
//   mem_wdata   out  32  instruction word to write
//   cpu_hold    out  1   1 = core held with PC at BASE_ADDR, 0 = core runs
//   done        out  1   image loaded (sticky until RST)
//   error       out  1   frame rejected because count > MAX_WORDS (sticky)
// -----------------------------------------------------------------------------
module prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  // One extra bit so that the limit comparison cannot overflow.
  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] wdata_q, wdata_d;

  // Full count as it will be once the low length byte is consumed.
  logic [15:0] len_full;
  logic [15:0] word_idx_inc;

  assign len_full     = {count_q[15:8], byte_data};
  assign word_idx_inc = word_idx_q + 16'd1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      wdata_q    <= wdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    wdata_d    = wdata_q;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    error      = 1'b0;

    case (state_q)
      S_IDLE: begin
        byte_ready = 1'b1;
        // Any byte other than the sync marker is dropped.
        if (byte_valid && byte_data == SYNC_BYTE) begin
          state_d = S_LEN_HI;
        end
      end

      S_LEN_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          count_d = {byte_data, 8'h00};
          state_d = S_LEN_LO;
        end
      end

      S_LEN_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          count_d = len_full;
          if (len_full == 16'd0) begin
            state_d = S_DONE;
          end else if ({1'b0, len_full} > MAX_W) begin
            state_d = S_ERR;
          end else begin
            state_d    = S_DATA;
            byte_idx_d = 2'd0;
            word_idx_d = 16'd0;
          end
        end
      end

      S_DATA: begin
        byte_ready = 1'b1;
        // While byte_valid is low the partial word is simply held.
        if (byte_valid) begin
          wdata_d    = {wdata_q[23:0], byte_data};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        // Single bubble per word; byte_ready stays low here.
        mem_we     = 1'b1;
        word_idx_d = word_idx_inc;
        state_d    = (word_idx_inc == count_q) ? S_DONE : S_DATA;
      end

      S_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
      end

      S_ERR: begin
        error = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_addr  = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//
// Self-checking bench for prog_loader. Expected writes are queued as stimulus
// is driven; a negedge monitor pops and compares each mem_we pulse.
// -----------------------------------------------------------------------------
module tb_prog_loader;

  logic        CLK;
  logic        RST;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  prog_loader #(
    .BASE_ADDR(32'h0000_0000),
    .MAX_WORDS(256),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks;
  int  errors;
  int  wr_count;
  int  stall_cycles;
  int  stall_we_bad;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Write scoreboard: every mem_we pulse must match the oldest expected write.
  always @(negedge CLK) begin
    if (!RST && mem_we === 1'b1) begin
      wr_t e;
      wr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h (no write expected)", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data) begin
          errors++;
          $display("FAIL write addr=%h data=%h expected addr=%h data=%h",
                   mem_addr, mem_wdata, e.addr, e.data);
        end else begin
          $display("write addr=%h data=%h ok", mem_addr, mem_wdata);
        end
      end
    end
  end

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Called at #1 after a rising edge; returns #1 after the consuming edge.
  // byte_valid is left high so consecutive calls model a held-valid stream.
  task automatic send_byte(input logic [7:0] b);
    int n;
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (byte_ready !== 1'b1 && n < 20) begin
      if (mem_we !== 1'b1) stall_we_bad++;
      stall_cycles++;
      @(posedge CLK); #1;
      n++;
    end
    if (byte_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout byte=%h byte_ready=%b expected 1", b, byte_ready);
    end else begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic do_reset();
    RST        = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({byte_ready, mem_we, cpu_hold, done, error} !== 5'b10100 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_state ready/we/hold/done/err=%b addr=%h wdata=%h expected 10100 0 0",
               {byte_ready, mem_we, cpu_hold, done, error}, mem_addr, mem_wdata);
    end else $display("reset state ok");
  endtask

  task automatic test_two_words();
    logic [7:0] s[11];
    s = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    push_wr(32'h0, 32'h2008_0005);
    push_wr(32'h4, 32'h0109_5020);
    for (int i = 0; i < 11; i++) send_byte(s[i]);
    checks++;
    if (mem_we !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL two_words_last_write we=%b done=%b expected we=1 done=0", mem_we, done);
    end
    byte_data = 8'hA5;     // valid kept high: nothing more may be consumed
    @(posedge CLK); #1;
    checks++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || byte_ready !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL two_words_done done=%b hold=%b ready=%b err=%b expected 1 0 0 0",
               done, cpu_hold, byte_ready, error);
    end else $display("two_words done ok");
    idle(3);
    checks++;
    if (wr_count != 2 || done !== 1'b1) begin
      errors++;
      $display("FAIL two_words_sticky writes=%0d done=%b expected 2 1", wr_count, done);
    end
  endtask

  task automatic test_sync_search_and_pause();
    logic [7:0] s[10];
    s = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_reset();
    wr_count = 0;
    push_wr(32'h0, 32'hAABB_CCDD);
    for (int i = 0; i < 10; i++) begin
      send_byte(s[i]);
      if (i == 7) begin
        idle(5);
        checks++;
        if (byte_ready !== 1'b1 || mem_we !== 1'b0) begin
          errors++;
          $display("FAIL pause_hold ready=%b we=%b expected 1 0", byte_ready, mem_we);
        end
      end
    end
    byte_valid = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || wr_count != 1) begin
      errors++;
      $display("FAIL sync_search done=%b hold=%b writes=%0d expected 1 0 1", done, cpu_hold, wr_count);
    end else $display("sync_search done ok");
  endtask

  task automatic test_zero_count();
    do_reset();
    wr_count = 0;
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    byte_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL zero_count done=%b hold=%b we=%b expected 1 0 0", done, cpu_hold, mem_we);
    end
    idle(4);
    checks++;
    if (wr_count != 0 || done !== 1'b1) begin
      errors++;
      $display("FAIL zero_count_nowrite writes=%0d done=%b expected 0 1", wr_count, done);
    end else $display("zero_count ok");
  endtask

  task automatic test_max_words();
    // 257 words: rejected
    do_reset();
    wr_count = 0;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h01);
    byte_data = 8'h12;
    @(posedge CLK); #1;
    checks++;
    if (error !== 1'b1 || cpu_hold !== 1'b1 || byte_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL over_max err=%b hold=%b ready=%b done=%b expected 1 1 0 0",
               error, cpu_hold, byte_ready, done);
    end
    idle(3);
    checks++;
    if (wr_count != 0 || error !== 1'b1) begin
      errors++;
      $display("FAIL over_max_nowrite writes=%0d err=%b expected 0 1", wr_count, error);
    end else $display("over_max rejected ok");

    // Exactly 256 words: accepted, all written, last address 0x3FC
    do_reset();
    wr_count = 0;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    checks++;
    if (error !== 1'b0 || byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL at_max_accept err=%b ready=%b expected 0 1", error, byte_ready);
    end
    for (int w = 0; w < 256; w++) begin
      logic [31:0] d;
      d = {w[15:0] ^ 16'h5A3C, ~w[15:0]};
      push_wr(32'(w) << 2, d);
      send_byte(d[31:24]);
      send_byte(d[23:16]);
      send_byte(d[15:8]);
      send_byte(d[7:0]);
    end
    byte_valid = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || wr_count != 256) begin
      errors++;
      $display("FAIL at_max_done done=%b err=%b writes=%0d expected 1 0 256", done, error, wr_count);
    end else $display("at_max 256 words ok");
  endtask

  task automatic test_back_to_back();
    logic [7:0] s[12];
    s = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h55, 8'h66, 8'h77, 8'h88, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    do_reset();
    wr_count = 0;
    push_wr(32'h0, 32'h1020_3040);
    push_wr(32'h4, 32'h5566_7788);
    push_wr(32'h8, 32'hDEAD_BEEF);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h03);
    stall_cycles = 0;
    stall_we_bad = 0;
    for (int i = 0; i < 12; i++) send_byte(s[i]);
    checks++;
    if (stall_cycles != 2 || stall_we_bad != 0) begin
      errors++;
      $display("FAIL back_to_back_stalls stalls=%0d stalls_without_we=%0d expected 2 0",
               stall_cycles, stall_we_bad);
    end
    @(posedge CLK); #1;
    byte_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || wr_count != 3) begin
      errors++;
      $display("FAIL back_to_back_done done=%b writes=%0d expected 1 3", done, wr_count);
    end else $display("back_to_back ok");
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    wr_count = 0;
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hDE);
    send_byte(8'hAD);
    do_reset();
    idle(3);
    checks++;
    if ({byte_ready, mem_we, cpu_hold, done, error} !== 5'b10100 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0 || wr_count != 0) begin
      errors++;
      $display("FAIL mid_reset ready/we/hold/done/err=%b addr=%h wdata=%h writes=%0d expected 10100 0 0 0",
               {byte_ready, mem_we, cpu_hold, done, error}, mem_addr, mem_wdata, wr_count);
    end
    push_wr(32'h0, 32'h1122_3344);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    byte_valid = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (done !== 1'b1 || wr_count != 1) begin
      errors++;
      $display("FAIL mid_reset_reload done=%b writes=%0d expected 1 1", done, wr_count);
    end else $display("mid_reset reload ok");
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    wr_count     = 0;
    stall_cycles = 0;
    stall_we_bad = 0;
    RST          = 1'b1;
    byte_valid   = 1'b0;
    byte_data    = 8'h00;
    test_reset();
    test_two_words();
    test_sync_search_and_pause();
    test_zero_count();
    test_max_words();
    test_back_to_back();
    test_reset_mid_frame();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_writes left=%0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
